// File: rtl/imem_loader.sv
// UART boot loader: receives a little-endian word count followed by that many
// 32-bit words over 8N1 serial and writes them into instruction memory.
module imem_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          MAX_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_st_t;
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR} load_st_t;

  logic             rx_p0, rx_p1;
  uart_st_t         u_st, u_st_nxt;
  logic [CNT_W-1:0] u_cnt, u_cnt_nxt;
  logic [2:0]       u_bit, u_bit_nxt;
  logic [7:0]       u_shift, u_shift_nxt;
  logic             byte_valid, frame_err;

  load_st_t         l_st, l_st_nxt;
  logic [1:0]       l_bcnt, l_bcnt_nxt;
  logic [IDX_W-1:0] l_idx, l_idx_nxt;
  logic [IDX_W-1:0] l_n, l_n_nxt;
  logic [31:0]      asm_w, asm_nxt, word_in;
  logic [3:0]       we_nxt;
  logic [31:0]      addr_nxt, wdata_nxt;
  logic             err_q, err_nxt;

  // Stage p0/p1: rx metastability synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // UART receiver: samples at bit midpoints, timed from the start-bit midpoint
  always_comb begin
    u_st_nxt    = u_st;
    u_cnt_nxt   = u_cnt + 1'b1;
    u_bit_nxt   = u_bit;
    u_shift_nxt = u_shift;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    case (u_st)
      U_IDLE: begin
        u_cnt_nxt = '0;
        if (!rx_p1) u_st_nxt = U_START;
      end
      U_START: if (u_cnt == HALF_BIT) begin
        u_cnt_nxt = '0;
        u_bit_nxt = '0;
        u_st_nxt  = rx_p1 ? U_IDLE : U_DATA;
      end
      U_DATA: if (u_cnt == FULL_BIT) begin
        u_cnt_nxt   = '0;
        u_shift_nxt = {rx_p1, u_shift[7:1]};
        u_bit_nxt   = u_bit + 3'd1;
        if (u_bit == 3'd7) u_st_nxt = U_STOP;
      end
      U_STOP: if (u_cnt == FULL_BIT) begin
        u_cnt_nxt = '0;
        u_st_nxt  = U_IDLE;
        if (rx_p1) byte_valid = 1'b1;
        else       frame_err  = 1'b1;
      end
      default: u_st_nxt = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_st  <= U_IDLE;
      u_cnt <= '0;
      u_bit <= '0;
    end else begin
      u_st  <= u_st_nxt;
      u_cnt <= u_cnt_nxt;
      u_bit <= u_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    u_shift <= u_shift_nxt;
    asm_w   <= asm_nxt;
  end

  // Each received byte enters at the top, so the first byte of a word ends in bits 7:0
  assign word_in = {u_shift, asm_w[31:8]};

  always_comb begin
    l_st_nxt   = l_st;
    l_bcnt_nxt = l_bcnt;
    l_idx_nxt  = l_idx;
    l_n_nxt    = l_n;
    asm_nxt    = asm_w;
    we_nxt     = 4'b0000;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    case (l_st)
      L_LEN: begin
        if (frame_err) begin
          l_st_nxt = L_ERR;
        end else if (byte_valid) begin
          asm_nxt    = word_in;
          l_bcnt_nxt = l_bcnt + 2'd1;
          if (l_bcnt == 2'd3) begin
            if (word_in == 32'd0) begin
              l_st_nxt = L_DONE;
            end else if (word_in > 32'(MAX_WORDS)) begin
              l_st_nxt = L_ERR;
            end else begin
              l_st_nxt  = L_DATA;
              l_idx_nxt = '0;
              l_n_nxt   = IDX_W'(word_in);
            end
          end
        end
      end
      L_DATA: begin
        if (frame_err) begin
          l_st_nxt = L_ERR;
        end else if (mem_we[0] && (l_idx == l_n)) begin
          // The last word's write is on the bus this cycle
          l_st_nxt = L_DONE;
        end else if (byte_valid) begin
          asm_nxt    = word_in;
          l_bcnt_nxt = l_bcnt + 2'd1;
          if (l_bcnt == 2'd3) begin
            we_nxt    = 4'b1111;
            addr_nxt  = BASE_ADDR + (32'(l_idx) << 2);
            wdata_nxt = word_in;
            l_idx_nxt = l_idx + 1'b1;
          end
        end
      end
      default: ;
    endcase
    err_nxt = err_q | frame_err | (l_st_nxt == L_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_st      <= L_LEN;
      l_bcnt    <= '0;
      l_idx     <= '0;
      l_n       <= '0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_q     <= 1'b0;
    end else begin
      l_st      <= l_st_nxt;
      l_bcnt    <= l_bcnt_nxt;
      l_idx     <= l_idx_nxt;
      l_n       <= l_n_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      err_q     <= err_nxt;
    end
  end

  // busy is qualified by rst_n so it reads 0 during reset yet 1 on the first cycle after
  assign busy      = rst_n & ((l_st == L_LEN) | (l_st == L_DATA));
  assign done      = (l_st == L_DONE);
  assign cpu_rst_n = (l_st == L_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: serializes images over rx and compares the
// observed memory writes and status flags against a queue-based image model.
module tb_imem_loader;
  localparam int          CPB  = 16;
  localparam int          MAXW = 4096;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        cpu_rst_n, busy, done, err;

  imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: one entry per cycle with any byte enable asserted
  int          cyc = 0, last_we_cyc = 0, done_cyc = 0;
  logic [31:0] wa_q[$], wd_q[$];
  logic [3:0]  we_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      wa_q.delete(); wd_q.delete(); we_q.delete();
      last_we_cyc = 0;
      done_cyc = 0;
    end else begin
      if (mem_we != 4'b0000) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
        we_q.push_back(mem_we);
        last_we_cyc = cyc;
      end
      if (done && done_cyc == 0) done_cyc = cyc;
    end
  end

  logic [31:0] img[$];

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    rx = 1'b1;
    repeat (CPB + $urandom_range(0, CPB)) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_image();
    send_word(32'(img.size()));
    foreach (img[i]) send_word(img[i]);
  endtask

  task automatic do_reset(input bit check_outputs);
    rst_n = 1'b0;
    rx = 1'b1;
    idle(3);
    if (check_outputs) begin
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
    end
    rst_n = 1'b1;
    #1;
    if (check_outputs) begin
      chk("busy_after_rst", 32'(busy), 32'h1);
      chk("cpu_rst_after_rst", 32'(cpu_rst_n), 32'h0);
    end
    idle(2);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20000 && !done; i++) @(posedge clk);
    idle(2);
    chk({tag, "_done"}, 32'(done), 32'h1);
  endtask

  // Expected writes come straight from the image: word k lands at BASE + 4k
  task automatic check_image(input string tag);
    wait_done(tag);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(img.size()));
    for (int i = 0; i < img.size() && i < wa_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa_q[i], BASE + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wd_q[i], img[i]);
      chk($sformatf("%s_we%0d", tag, i), 32'(we_q[i]), 32'hF);
    end
  endtask

  initial begin
    do_reset(1'b1);

    // Two-instruction image with done latency relative to the final write
    img = '{32'h0000_0513, 32'h0010_0593};
    send_image();
    check_image("n2");
    chk("n2_done_latency", 32'(done_cyc - last_we_cyc), 32'd1);

    // Empty image
    do_reset(1'b0);
    img.delete();
    send_word(32'd0);
    check_image("n0");

    // Oversized length header
    do_reset(1'b0);
    send_word(32'd4097);
    idle(4);
    chk("len_err", 32'(err), 32'h1);
    chk("len_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("len_busy", 32'(busy), 32'h0);
    chk("len_done", 32'(done), 32'h0);
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    idle(4);
    chk("len_nwrites", 32'(wa_q.size()), 32'h0);
    chk("len_cpu_rst_n_late", 32'(cpu_rst_n), 32'h0);

    // Short low glitch must not start a byte
    do_reset(1'b0);
    rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk);
    #1;
    rx = 1'b1;
    idle(3 * CPB);
    img = '{$urandom(), $urandom()};
    send_image();
    check_image("glitch");

    // Framing error on the first data byte
    do_reset(1'b0);
    send_word(32'd1);
    send_byte(8'h13, 1'b0);
    idle(4);
    chk("frm_err", 32'(err), 32'h1);
    chk("frm_nwrites", 32'(wa_q.size()), 32'h0);
    chk("frm_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("frm_busy", 32'(busy), 32'h0);

    // Reset in the middle of a load restarts from the header
    do_reset(1'b0);
    send_word(32'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    do_reset(1'b0);
    img = '{32'hDDCC_BBAA};
    send_image();
    check_image("rst_mid");

    // Random images
    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0);
      img.delete();
      for (int k = 0, n = $urandom_range(1, 5); k < n; k++) img.push_back($urandom());
      send_image();
      check_image($sformatf("rnd%0d", t));
    end

    // Bytes after completion are ignored; a framing error only raises err
    send_word($urandom());
    idle(4);
    chk("post_nwrites", 32'(wa_q.size()), 32'(img.size()));
    send_byte(8'h55, 1'b0);
    idle(4);
    chk("post_frm_err", 32'(err), 32'h1);
    chk("post_frm_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("post_frm_done", 32'(done), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter MAX_WORDS, default 4096: largest image, in 32-bit words.
REQ-003 Parameter BASE_ADDR, default 32'h0: byte address of the first image word.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rx  in  1  UART serial input, 8N1, LSB first, idle high; asynchronous to clk.
REQ-007 mem_we  out  4  byte write enables to the instruction memory write port.
REQ-008 mem_addr  out  32  byte address of the write; always word-aligned.
REQ-009 mem_wdata  out  32  write data.
REQ-010 cpu_rst_n  out  1  active-low reset held on the CPU until the image is loaded.
REQ-011 busy  out  1  high while a load is in progress (LEN or DATA state).
REQ-012 done  out  1  high once the image is fully written; sticky until rst_n.
REQ-013 err  out  1  high on a framing or length error; sticky until rst_n.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all detection SHALL use the synchronized value.
REQ-015 UART RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on synchronized rx = 0.
REQ-016 START SHALL resample rx after CLKS_PER_BIT/2 cycles.
- rx = 1: glitch; return to IDLE with no byte.
- rx = 0: go to DATA.
REQ-017 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
REQ-018 STOP SHALL sample once after CLKS_PER_BIT cycles.
- rx = 1: emit a one-cycle byte_valid with the byte.
- rx = 0: framing error; set err, discard the byte.
- Either case: return to IDLE.
REQ-019 Loader FSM states: LEN, DATA, DONE, ERR; LEN entered after reset.
REQ-020 LEN SHALL collect 4 bytes, little-endian, into the word count N.
REQ-021 On the 4th LEN byte:
- N = 0 -> DONE.
- N > MAX_WORDS -> ERR.
- Otherwise -> DATA with word index = 0.
REQ-022 DATA SHALL assemble 4 bytes little-endian per word (first byte -> bits 7:0).
REQ-023 The cycle after the 4th byte of word k, the block SHALL drive for exactly one cycle:
- mem_we = 4'b1111;
- mem_addr = BASE_ADDR + 4*k;
- mem_wdata = the assembled word.
REQ-024 mem_we SHALL be 4'b0000 in all other cycles; mem_addr and mem_wdata are don't-care while mem_we = 0.
REQ-025 After the write of word N-1, the FSM SHALL enter DONE on the following edge.
REQ-026 In DONE, done = 1 and cpu_rst_n = 1 from that same cycle onward.
REQ-027 In DONE, all further received bytes SHALL be ignored with no memory writes.
REQ-028 Any framing error in LEN or DATA SHALL move the FSM to ERR.
REQ-029 In ERR: cpu_rst_n = 0, err = 1, no writes; only rst_n exits.
REQ-030 A framing error in DONE SHALL set err but SHALL NOT deassert cpu_rst_n.
REQ-031 The word index and byte counters SHALL be wide enough for MAX_WORDS with no wrap-around.
REQ-032 cpu_rst_n SHALL be 0 in LEN, DATA and ERR.

Reset
REQ-033 While rst_n = 0, outputs SHALL be: mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_rst_n = 0, busy = 0, done = 0, err = 0.
REQ-034 While rst_n = 0, the UART FSM SHALL be in IDLE, the loader FSM in LEN, all counters 0, and both synchronizer flops 1.
REQ-035 The first cycle after rst_n release SHALL give busy = 1.
REQ-036 Reset asserted mid-load SHALL abort the load immediately; the image restarts from the LEN header.

Verification
REQ-037 Send N = 2 (bytes 02 00 00 00), then 13 05 00 00 and 93 05 10 00 -> writes:
- 0x00000513 @ 0x0;
- 0x00100593 @ 0x4;
- done = 1 and cpu_rst_n = 1 one cycle after the second write.
REQ-038 Send N = 0 -> done = 1 and cpu_rst_n = 1 with no mem_we pulse.
REQ-039 Send N = 4097 (01 10 00 00) with MAX_WORDS = 4096 -> err = 1, FSM in ERR, cpu_rst_n stays 0, later bytes cause no writes.
REQ-040 Send a 0.3-bit-wide low glitch on rx, then a valid load -> glitch ignored, err = 0, load completes.
REQ-041 Send the byte for word 0 with its stop bit driven low -> err = 1, no write at 0x0, cpu_rst_n = 0.
REQ-042 Assert rst_n after the 2nd data byte, release it, resend the full N = 1 image AABBCCDD -> single write of 0xDDCCBBAA @ 0x0, then done = 1.
